// File: rtl/memory.sv
// memory: pipeline memory stage issuing one data-bus transaction per aligned load/store.
// dataE/dataM layout: [170:165] op, [164:160] dst, [159:128] instr, [127:64] aluout, [63:0] rd.
module memory (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [170:0] dataE,
  output logic         stall,
  output logic         dreq_valid,
  output logic [63:0]  dreq_addr,
  output logic [2:0]   dreq_size,
  output logic [7:0]   dreq_strobe,
  output logic [63:0]  dreq_data,
  input  logic         dresp_addr_ok,
  input  logic         dresp_data_ok,
  input  logic [63:0]  dresp_data,
  output logic         out_valid,
  output logic [170:0] dataM,
  output logic         out_misalign
);
  localparam logic [5:0] LB = 6'd2, LH = 6'd3, LW = 6'd4, LD = 6'd5, LBU = 6'd6, LHU = 6'd7, LWU = 6'd8;
  localparam logic [5:0] SB = 6'd9, SH = 6'd10, SW = 6'd11, SD = 6'd12;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [5:0] op, hop;
  logic [63:0] addr, rd, hold_addr, lane, ld_val, wmask;
  logic is_load, is_store, mis, accept, done;
  logic [1:0] size;
  logic [2:0] amask;
  logic [170:0] held;
  assign op = dataE[170:165];
  assign addr = dataE[127:64];
  assign rd = dataE[63:0];
  assign hop = held[170:165];
  assign hold_addr = held[127:64];
  always_comb begin
    is_load = op inside {LB, LH, LW, LD, LBU, LHU, LWU};
    is_store = op inside {SB, SH, SW, SD};
    size = (op == LB || op == LBU || op == SB) ? 2'd0 :
           (op == LH || op == LHU || op == SH) ? 2'd1 :
           (op == LW || op == LWU || op == SW) ? 2'd2 : 2'd3;
    amask = size == 2'd0 ? 3'd0 : size == 2'd1 ? 3'd1 : size == 2'd2 ? 3'd3 : 3'd7;
    mis = (addr[2:0] & amask) != 3'd0;
    wmask = size == 2'd0 ? 64'hFF : size == 2'd1 ? 64'hFFFF : size == 2'd2 ? 64'hFFFF_FFFF : '1;
    accept = state == IDLE && in_valid && (is_load || is_store) && !mis;
    done = (state == REQ && dresp_addr_ok && dresp_data_ok) || (state == WAIT && dresp_data_ok);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (accept ? REQ : IDLE) :
              state == REQ  ? (dresp_addr_ok ? (dresp_data_ok ? IDLE : WAIT) : REQ) :
                              (dresp_data_ok ? IDLE : WAIT);
  end
  always_comb begin
    stall = state != IDLE || accept;
    dreq_valid = state != IDLE;
  end
  // Byte lane selected by the latched address, then extended by the latched op.
  always_comb begin
    lane = dresp_data >> {hold_addr[2:0], 3'b000};
    ld_val = hop == LB  ? {{56{lane[7]}}, lane[7:0]} :
             hop == LH  ? {{48{lane[15]}}, lane[15:0]} :
             hop == LW  ? {{32{lane[31]}}, lane[31:0]} :
             hop == LBU ? {56'd0, lane[7:0]} :
             hop == LHU ? {48'd0, lane[15:0]} :
             hop == LWU ? {32'd0, lane[31:0]} :
             hop == LD  ? dresp_data : hold_addr;
  end
  assign dreq_addr = hold_addr;
  always_ff @(posedge clk)
    if (reset) begin
      held <= '0;
      dreq_size <= '0;
      dreq_strobe <= '0;
      dreq_data <= '0;
      out_valid <= 1'b0;
      out_misalign <= 1'b0;
      dataM <= '0;
    end else begin
      if (accept) begin
        held <= dataE;
        dreq_size <= {1'b0, size};
        dreq_strobe <= is_store ? 8'((9'h1 << (4'd1 << size)) - 9'h1) << addr[2:0] : 8'h00;
        dreq_data <= (rd & wmask) << {addr[2:0], 3'b000};
      end
      out_valid <= (state == IDLE && in_valid && !accept) || done;
      out_misalign <= state == IDLE && in_valid && (is_load || is_store) && mis;
      if (done) dataM <= {held[170:128], ld_val, held[63:0]};
      else if (state == IDLE && in_valid && !accept) dataM <= dataE;
    end
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed checks of the memory stage with hand-computed expectations.
module tb_memory;
  localparam logic [5:0] ADDW = 6'd1, LB = 6'd2, LH = 6'd3, LW = 6'd4, LD = 6'd5, LBU = 6'd6;
  localparam logic [5:0] SH = 6'd10, SW = 6'd11;
  logic clk = 0, reset = 1, in_valid = 0, stall, dreq_valid, dresp_addr_ok = 0, dresp_data_ok = 0;
  logic out_valid, out_misalign;
  logic [170:0] dataE = '0, dataM;
  logic [63:0] dreq_addr, dreq_data, dresp_data = '0;
  logic [2:0] dreq_size;
  logic [7:0] dreq_strobe;
  int errors = 0, checks = 0, pulses;
  memory dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .dataE(dataE), .stall(stall),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .out_valid(out_valid),
    .dataM(dataM), .out_misalign(out_misalign)
  );
  always #5 clk = ~clk;
  function automatic logic [170:0] mk(logic [5:0] op, logic [4:0] dst, logic [63:0] a, logic [63:0] r);
    return {op, dst, 32'h0000_0013, a, r};
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick; tick;
    reset = 0;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_dreq_valid", 64'(dreq_valid), 0);
    chk("rst_strobe", 64'(dreq_strobe), 0);
    chk("rst_dataM_alu", dataM[127:64], 0);
    // ADDW passes straight through
    dataE = mk(ADDW, 5'd3, 64'h55, 64'h0); in_valid = 1; #1;
    chk("addw_stall", 64'(stall), 0);
    tick; in_valid = 0;
    chk("addw_out_valid", 64'(out_valid), 1);
    chk("addw_alu", dataM[127:64], 64'h55);
    chk("addw_dreq_valid", 64'(dreq_valid), 0);
    chk("addw_misalign", 64'(out_misalign), 0);
    tick;
    chk("addw_pulse_end", 64'(out_valid), 0);
    // LB sign extension with addr_ok and data_ok together
    dataE = mk(LB, 5'd4, 64'h1003, 64'h0); in_valid = 1; #1;
    chk("lb_stall_comb", 64'(stall), 1);
    tick; in_valid = 0;
    chk("lb_dreq_valid", 64'(dreq_valid), 1);
    chk("lb_addr", dreq_addr, 64'h1003);
    chk("lb_size", 64'(dreq_size), 0);
    chk("lb_strobe", 64'(dreq_strobe), 0);
    dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h0000_0000_8000_0000;
    tick; dresp_addr_ok = 0; dresp_data_ok = 0;
    chk("lb_out_valid", 64'(out_valid), 1);
    chk("lb_result", dataM[127:64], 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_dst", 64'(dataM[164:160]), 4);
    chk("lb_stall_after", 64'(stall), 0);
    chk("lb_dreq_after", 64'(dreq_valid), 0);
    // LBU zero extension
    dataE = mk(LBU, 5'd5, 64'h1003, 64'h0); in_valid = 1;
    tick; in_valid = 0;
    dresp_addr_ok = 1; dresp_data_ok = 1;
    tick; dresp_addr_ok = 0; dresp_data_ok = 0;
    chk("lbu_result", dataM[127:64], 64'h80);
    // LH sign extension from lane 2
    dataE = mk(LH, 5'd6, 64'h6002, 64'h0); in_valid = 1;
    tick; in_valid = 0;
    dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 64'h0000_0000_8001_0000;
    tick; dresp_addr_ok = 0; dresp_data_ok = 0;
    chk("lh_result", dataM[127:64], 64'hFFFF_FFFF_FFFF_8001);
    // SH with addr_ok held low for three cycles
    dataE = mk(SH, 5'd0, 64'h2006, 64'h1234); in_valid = 1;
    tick; in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_stall", 64'(stall), 1);
      chk("sh_dreq_valid", 64'(dreq_valid), 1);
      chk("sh_strobe", 64'(dreq_strobe), 64'hC0);
      chk("sh_data", dreq_data, 64'h1234_0000_0000_0000);
      chk("sh_size", 64'(dreq_size), 1);
      chk("sh_addr", dreq_addr, 64'h2006);
      chk("sh_no_out", 64'(out_valid), 0);
      tick;
    end
    dresp_addr_ok = 1;
    tick; dresp_addr_ok = 0;
    chk("sh_wait_dreq", 64'(dreq_valid), 1);
    chk("sh_wait_stall", 64'(stall), 1);
    chk("sh_wait_strobe", 64'(dreq_strobe), 64'hC0);
    dresp_data_ok = 1;
    tick; dresp_data_ok = 0;
    chk("sh_out_valid", 64'(out_valid), 1);
    chk("sh_alu", dataM[127:64], 64'h2006);
    chk("sh_misalign", 64'(out_misalign), 0);
    chk("sh_dreq_after", 64'(dreq_valid), 0);
    // SW in upper word
    dataE = mk(SW, 5'd0, 64'h5004, 64'hDEAD_BEEF_CAFE_F00D); in_valid = 1;
    tick; in_valid = 0;
    chk("sw_strobe", 64'(dreq_strobe), 64'hF0);
    chk("sw_data", dreq_data, 64'hCAFE_F00D_0000_0000);
    chk("sw_size", 64'(dreq_size), 2);
    dresp_addr_ok = 1; dresp_data_ok = 1;
    tick; dresp_addr_ok = 0; dresp_data_ok = 0;
    chk("sw_out_valid", 64'(out_valid), 1);
    // Misaligned LW
    dataE = mk(LW, 5'd7, 64'h1002, 64'h0); in_valid = 1; #1;
    chk("lw_mis_stall", 64'(stall), 0);
    tick; in_valid = 0;
    chk("lw_mis_dreq", 64'(dreq_valid), 0);
    chk("lw_mis_valid", 64'(out_valid), 1);
    chk("lw_mis_flag", 64'(out_misalign), 1);
    chk("lw_mis_alu", dataM[127:64], 64'h1002);
    tick;
    chk("lw_mis_flag_clr", 64'(out_misalign), 0);
    // Reset in WAIT, then stale data_ok
    dataE = mk(LD, 5'd8, 64'h3000, 64'h0); in_valid = 1;
    tick; in_valid = 0; dresp_addr_ok = 1;
    tick; dresp_addr_ok = 0;
    chk("rw_in_wait", 64'(dreq_valid), 1);
    reset = 1;
    tick; reset = 0;
    chk("rw_dreq", 64'(dreq_valid), 0);
    chk("rw_out_valid", 64'(out_valid), 0);
    chk("rw_stall", 64'(stall), 0);
    chk("rw_dataM", dataM[127:64], 0);
    dresp_data_ok = 1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick; dresp_data_ok = 0;
    chk("rw_stale_valid", 64'(out_valid), 0);
    chk("rw_stale_dreq", 64'(dreq_valid), 0);
    chk("rw_stale_strobe", 64'(dreq_strobe), 0);
    // Second LD during WAIT ignored
    pulses = 0;
    dataE = mk(LD, 5'd9, 64'h4000, 64'h0); in_valid = 1;
    tick; dresp_addr_ok = 1;
    dataE = mk(LD, 5'd10, 64'h4008, 64'h0);
    tick; dresp_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      pulses += int'(out_valid);
      chk("ld2_addr_hold", dreq_addr, 64'h4000);
      tick;
    end
    pulses += int'(out_valid);
    in_valid = 0; dresp_data_ok = 1; dresp_data = 64'h1122_3344_5566_7788;
    tick; dresp_data_ok = 0;
    chk("ld2_out_valid", 64'(out_valid), 1);
    chk("ld2_result", dataM[127:64], 64'h1122_3344_5566_7788);
    chk("ld2_dst", 64'(dataM[164:160]), 9);
    pulses += int'(out_valid);
    tick;
    pulses += int'(out_valid);
    tick;
    pulses += int'(out_valid);
    chk("ld2_pulses", 64'(pulses), 1);
    chk("ld2_idle", 64'(dreq_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
